// File: rtl/counter_wrap_monitor_pkg.sv
// Shared types for counter_wrap_monitor: FSM state and fault code encodings.
package counter_wrap_monitor_pkg;

  localparam int unsigned FAULT_W = 2;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StFault
  } state_e;

  typedef enum logic [FAULT_W-1:0] {
    FaultNone  = 2'd0,
    FaultStep  = 2'd1,
    FaultRange = 2'd2
  } fault_code_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr has priority over inc.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/counter_wrap_monitor.sv
// Observer for a modulo counter: checks steps, measures wrap period, sticky coded fault.
// Define COUNTER_WRAP_MONITOR_ASSERT_EN to add concurrent assertions.
module counter_wrap_monitor
  import counter_wrap_monitor_pkg::*;
#(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned WRAP_MAX = 22,
  parameter int unsigned STAT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   count,
  input  logic               count_valid,
  input  logic               clear,
  output logic               active,
  output logic               wrap_pulse,
  output logic [STAT_W-1:0]  wrap_count,
  output logic [STAT_W-1:0]  period_last,
  output logic               period_valid,
  output logic               fault,
  output logic [FAULT_W-1:0] fault_code
);

  state_e              state_q, state_d;
  fault_code_e         fault_code_q, fault_code_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [STAT_W-1:0]   period_last_q, period_last_d;
  logic                period_valid_q, period_valid_d;
  logic                seen_wrap_q, seen_wrap_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic                fault_q, fault_d;
  logic                active_q, active_d;
  logic                wrap_inc, period_inc;
  logic [STAT_W-1:0]   period_cnt;
  logic [WIDTH-1:0]    exp_count;
  logic                out_of_range;

  assign exp_count    = (prev_q == WIDTH'(WRAP_MAX)) ? '0 : prev_q + WIDTH'(1);
  assign out_of_range = count > WIDTH'(WRAP_MAX);

  always_comb begin
    state_d        = state_q;
    fault_code_d   = fault_code_q;
    prev_d         = prev_q;
    period_last_d  = period_last_q;
    period_valid_d = period_valid_q;
    seen_wrap_d    = seen_wrap_q;
    wrap_pulse_d   = 1'b0;
    fault_d        = fault_q;
    wrap_inc       = 1'b0;
    period_inc     = 1'b0;
    if (clear) begin
      state_d        = StIdle;
      fault_code_d   = FaultNone;
      prev_d         = '0;
      period_last_d  = '0;
      period_valid_d = 1'b0;
      seen_wrap_d    = 1'b0;
      fault_d        = 1'b0;
    end else if (count_valid) begin
      unique case (state_q)
        StIdle: begin
          if (out_of_range) begin
            state_d      = StFault;
            fault_d      = 1'b1;
            fault_code_d = FaultRange;
          end else begin
            state_d = StTrack;
            prev_d  = count;
          end
        end
        StTrack: begin
          if (out_of_range) begin
            state_d      = StFault;
            fault_d      = 1'b1;
            fault_code_d = FaultRange;
          end else if (count != exp_count) begin
            state_d      = StFault;
            fault_d      = 1'b1;
            fault_code_d = FaultStep;
          end else begin
            prev_d = count;
            if (exp_count == '0) begin
              wrap_pulse_d   = 1'b1;
              wrap_inc       = 1'b1;
              period_last_d  = (period_cnt == '1) ? period_cnt : period_cnt + STAT_W'(1);
              // The first wrap after IDLE closes a partial period only.
              period_valid_d = seen_wrap_q;
              seen_wrap_d    = 1'b1;
            end else begin
              period_inc = 1'b1;
            end
          end
        end
        StFault: ;
        default: ;
      endcase
    end
    active_d = (state_d == StTrack);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      fault_code_q   <= FaultNone;
      prev_q         <= '0;
      period_last_q  <= '0;
      period_valid_q <= 1'b0;
      seen_wrap_q    <= 1'b0;
      wrap_pulse_q   <= 1'b0;
      fault_q        <= 1'b0;
      active_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      fault_code_q   <= fault_code_d;
      prev_q         <= prev_d;
      period_last_q  <= period_last_d;
      period_valid_q <= period_valid_d;
      seen_wrap_q    <= seen_wrap_d;
      wrap_pulse_q   <= wrap_pulse_d;
      fault_q        <= fault_d;
      active_q       <= active_d;
    end
  end

  sat_counter #(
    .W(STAT_W)
  ) u_wrap_count (
    .clock(clock),
    .reset(reset),
    .inc  (wrap_inc),
    .clr  (clear),
    .value(wrap_count)
  );

  sat_counter #(
    .W(STAT_W)
  ) u_period_cnt (
    .clock(clock),
    .reset(reset),
    .inc  (period_inc),
    .clr  (clear | wrap_inc),
    .value(period_cnt)
  );

  assign active       = active_q;
  assign wrap_pulse   = wrap_pulse_q;
  assign period_last  = period_last_q;
  assign period_valid = period_valid_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;

`ifdef COUNTER_WRAP_MONITOR_ASSERT_EN
  a_step_legal: assert property (@(posedge clock) disable iff (!reset || clear)
    count_valid && active |=> fault == 1'b0);
  a_pulse_single: assert property (@(posedge clock) disable iff (!reset || clear)
    wrap_pulse |-> !$past(wrap_pulse));
  a_fault_sticky: assert property (@(posedge clock) disable iff (!reset || clear)
    fault |=> fault);
`endif

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Directed bench for counter_wrap_monitor with hand-computed expectations.
module tb_counter_wrap_monitor;

  logic       clock;
  logic       reset;
  logic [4:0] count;
  logic       count_valid;
  logic       clear;
  logic       active;
  logic       wrap_pulse;
  logic [7:0] wrap_count;
  logic [7:0] period_last;
  logic       period_valid;
  logic       fault;
  logic [1:0] fault_code;

  int checks;
  int failures;

  counter_wrap_monitor #(
    .WIDTH   (5),
    .WRAP_MAX(22),
    .STAT_W  (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .count       (count),
    .count_valid (count_valid),
    .clear       (clear),
    .active      (active),
    .wrap_pulse  (wrap_pulse),
    .wrap_count  (wrap_count),
    .period_last (period_last),
    .period_valid(period_valid),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Apply one sample on a negedge, then settle just after the following posedge.
  task automatic drive(input logic v, input logic [4:0] c);
    @(negedge clock);
    count       = c;
    count_valid = v;
    clear       = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear       = 1'b1;
    count_valid = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    clear       = 1'b0;
    count       = 5'd0;
    count_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({active, wrap_pulse, wrap_count, period_last, period_valid, fault, fault_code} !== '0) begin
      failures++;
      $display("FAIL reset_outputs act=%0b wp=%0b wc=%0d pl=%0d pv=%0b f=%0b fc=%0d exp all 0",
               active, wrap_pulse, wrap_count, period_last, period_valid, fault, fault_code);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_legal_run();
    logic [4:0] c;
    logic       exp_wp;
    for (int i = 0; i < 52; i++) begin
      c = 5'(i % 23);
      drive(1'b1, c);
      exp_wp = (c == 5'd0) && (i != 0);
      checks++;
      if (wrap_pulse !== exp_wp || fault !== 1'b0) begin
        failures++;
        $display("FAIL legal_step i=%0d wp=%0b exp=%0b fault=%0b exp=0", i, wrap_pulse, exp_wp,
                 fault);
      end
      if (i == 23) begin
        checks++;
        if (wrap_count !== 8'd1 || period_last !== 8'd23 || period_valid !== 1'b0) begin
          failures++;
          $display("FAIL legal_first_wrap wc=%0d pl=%0d pv=%0b exp 1 23 0", wrap_count,
                   period_last, period_valid);
        end
      end
    end
    checks++;
    if (wrap_count !== 8'd2 || period_last !== 8'd23 || period_valid !== 1'b1) begin
      failures++;
      $display("FAIL legal_stats wc=%0d pl=%0d pv=%0b exp 2 23 1", wrap_count, period_last,
               period_valid);
    end
    checks++;
    if (fault !== 1'b0 || fault_code !== 2'd0 || active !== 1'b1) begin
      failures++;
      $display("FAIL legal_status f=%0b fc=%0d act=%0b exp 0 0 1", fault, fault_code, active);
    end
  endtask

  task automatic test_step_error();
    do_clear();
    drive(1'b1, 5'd20);
    drive(1'b1, 5'd21);
    drive(1'b1, 5'd22);
    drive(1'b1, 5'd0);
    checks++;
    if (wrap_count !== 8'd1 || period_last !== 8'd3 || period_valid !== 1'b0) begin
      failures++;
      $display("FAIL step_pre_stats wc=%0d pl=%0d pv=%0b exp 1 3 0", wrap_count, period_last,
               period_valid);
    end
    for (int v = 1; v <= 7; v++) drive(1'b1, 5'(v));
    drive(1'b1, 5'd9);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || active !== 1'b0) begin
      failures++;
      $display("FAIL step_detect f=%0b fc=%0d act=%0b exp 1 1 0", fault, fault_code, active);
    end
    for (int v = 10; v <= 22; v++) drive(1'b1, 5'(v));
    drive(1'b1, 5'd0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd1 || wrap_pulse !== 1'b0 ||
        wrap_count !== 8'd1 || period_last !== 8'd3) begin
      failures++;
      $display("FAIL step_sticky f=%0b fc=%0d wp=%0b wc=%0d pl=%0d exp 1 1 0 1 3", fault,
               fault_code, wrap_pulse, wrap_count, period_last);
    end
  endtask

  task automatic test_range_error();
    do_clear();
    drive(1'b1, 5'd25);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd2 || active !== 1'b0) begin
      failures++;
      $display("FAIL range_idle f=%0b fc=%0d act=%0b exp 1 2 0", fault, fault_code, active);
    end
    do_clear();
    drive(1'b1, 5'd20);
    drive(1'b1, 5'd21);
    drive(1'b1, 5'd22);
    drive(1'b1, 5'd23);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'd2) begin
      failures++;
      $display("FAIL range_priority f=%0b fc=%0d exp 1 2", fault, fault_code);
    end
  endtask

  task automatic test_valid_gaps();
    logic [4:0] c;
    do_clear();
    drive(1'b1, 5'd0);
    for (int i = 1; i <= 46; i++) begin
      c = 5'(i % 23);
      drive(1'b1, c);
      if (i == 23) begin
        checks++;
        if (wrap_pulse !== 1'b1) begin
          failures++;
          $display("FAIL gap_wrap_pulse got=%0b exp=1", wrap_pulse);
        end
      end
      drive(1'b0, c ^ 5'h1F);
      if (i == 23) begin
        checks++;
        if (wrap_pulse !== 1'b0) begin
          failures++;
          $display("FAIL gap_pulse_width got=%0b exp=0", wrap_pulse);
        end
      end
    end
    checks++;
    if (period_last !== 8'd23 || period_valid !== 1'b1 || wrap_count !== 8'd2 ||
        fault !== 1'b0) begin
      failures++;
      $display("FAIL gap_stats pl=%0d pv=%0b wc=%0d f=%0b exp 23 1 2 0", period_last,
               period_valid, wrap_count, fault);
    end
  endtask

  task automatic test_clear_vs_sample();
    do_clear();
    drive(1'b1, 5'd5);
    drive(1'b1, 5'd9);
    @(negedge clock);
    clear       = 1'b1;
    count_valid = 1'b1;
    count       = 5'd3;
    @(posedge clock);
    #1;
    checks++;
    if ({active, wrap_pulse, wrap_count, period_last, period_valid, fault, fault_code} !== '0) begin
      failures++;
      $display("FAIL clear_wins act=%0b wp=%0b wc=%0d pl=%0d pv=%0b f=%0b fc=%0d exp all 0",
               active, wrap_pulse, wrap_count, period_last, period_valid, fault, fault_code);
    end
    drive(1'b1, 5'd14);
    drive(1'b1, 5'd15);
    checks++;
    if (active !== 1'b1 || fault !== 1'b0) begin
      failures++;
      $display("FAIL clear_baseline act=%0b f=%0b exp 1 0", active, fault);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5'd16);
    drive(1'b1, 5'd17);
    drive(1'b1, 5'd18);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if ({active, wrap_pulse, wrap_count, period_last, period_valid, fault, fault_code} !== '0) begin
      failures++;
      $display("FAIL async_reset act=%0b wp=%0b wc=%0d pl=%0d pv=%0b f=%0b fc=%0d exp all 0",
               active, wrap_pulse, wrap_count, period_last, period_valid, fault, fault_code);
    end
    count_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 5'd11);
    drive(1'b1, 5'd12);
    checks++;
    if (active !== 1'b1 || fault !== 1'b0 || fault_code !== 2'd0) begin
      failures++;
      $display("FAIL reset_resume act=%0b f=%0b fc=%0d exp 1 0 0", active, fault, fault_code);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_legal_run();
    test_step_error();
    test_range_error();
    test_valid_gaps();
    test_clear_vs_sample();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
